// File: rtl/clk_freq_meter_pkg.sv
// clk_freq_meter_pkg: shared states, saturation constants and the match helper
package clk_freq_meter_pkg;
    typedef enum logic [1:0] {IDLE, GATE, DONE} state_e;
    localparam int unsigned CNT_W_DEF = 16;
    // Widest supported counter; per-instance saturation values are slices of SAT_ALL
    localparam int unsigned MAX_W = 32;
    localparam logic [MAX_W-1:0] SAT_ALL = '1;
    // One extra bit of headroom so the difference never wraps
    function automatic logic [MAX_W:0] abs_diff(input logic [MAX_W:0] a, input logic [MAX_W:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/clk_freq_meter_if.sv
// clk_freq_meter_if: control/result bundle of the frequency meter
//   start, sig_in, exp_cnt          : requester -> meter
//   busy, valid, edge_cnt,
//   period_min, period_max, match   : meter -> requester
interface clk_freq_meter_if
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             start;
    logic             sig_in;
    logic [CNT_W-1:0] exp_cnt;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;
    logic             match;
    modport master (
        output start, sig_in, exp_cnt,
        input  busy, valid, edge_cnt, period_min, period_max, match
    );
    modport slave (
        input  start, sig_in, exp_cnt,
        output busy, valid, edge_cnt, period_min, period_max, match
    );
endinterface

// File: rtl/clk_freq_meter_edge_interval_tracker.sv
// edge_interval_tracker: rise detect, saturating edge count and min/max rise-to-rise interval
//   clk_in, rst : clock and synchronous active-high reset
//   clr_i       : clears count/interval state at window start
//   en_i        : window active, rises are evaluated
//   sig_i       : signal under test
//   cnt_o, min_o, max_o : next-state results, so a rise on the final window cycle is included
module edge_interval_tracker
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] min_o,
    output logic [CNT_W-1:0] max_o
);
    localparam logic [CNT_W-1:0] SAT = SAT_ALL[CNT_W-1:0];
    logic             sig_prev_q;
    logic             run_q, run_d;
    logic             have_q, have_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ivl_q, ivl_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             hit;
    logic             close;
    assign hit   = en_i & sig_i & ~sig_prev_q;
    // run_q: first rise seen; have_q: at least one interval closed
    assign close = hit & run_q;
    always_comb begin
        cnt_d  = clr_i ? '0 : (hit && cnt_q != SAT) ? cnt_q + 1'b1 : cnt_q;
        run_d  = clr_i ? 1'b0 : run_q | hit;
        ivl_d  = clr_i ? '0 : hit ? CNT_W'(1) : (run_q && en_i && ivl_q != SAT) ? ivl_q + 1'b1 : ivl_q;
        min_d  = clr_i ? '0 : (close && (!have_q || ivl_q < min_q)) ? ivl_q : min_q;
        max_d  = clr_i ? '0 : (close && (!have_q || ivl_q > max_q)) ? ivl_q : max_q;
        have_d = clr_i ? 1'b0 : have_q | close;
    end
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sig_prev_q <= 1'b0;
            run_q      <= 1'b0;
            have_q     <= 1'b0;
            cnt_q      <= '0;
            ivl_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
        end else begin
            sig_prev_q <= sig_i;
            run_q      <= run_d;
            have_q     <= have_d;
            cnt_q      <= cnt_d;
            ivl_q      <= ivl_d;
            min_q      <= min_d;
            max_q      <= max_d;
        end
    end
    assign cnt_o = cnt_d;
    assign min_o = min_d;
    assign max_o = max_d;
endmodule

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: gated edge counter and period min/max checker for divided clocks
//   clk_in : single clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : clk_freq_meter_if.slave (start/sig_in/exp_cnt in, busy/valid/results out)
// Optional: define CLK_FREQ_METER_SYNC_EN to pass sig_in through a 2-flop synchronizer.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TOL         = 1
) (
    input logic             clk_in,
    input logic             rst,
    clk_freq_meter_if.slave bus
);
    localparam int unsigned WIN_W = $clog2(GATE_CYCLES);
    localparam logic [WIN_W-1:0] LAST = WIN_W'(GATE_CYCLES - 1);
    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] pmin_q, pmin_d;
    logic [CNT_W-1:0] pmax_q, pmax_d;
    logic             match_q, match_d;
    logic             clr, en, load;
    logic             sig_s;
    logic [CNT_W-1:0] trk_cnt, trk_min, trk_max;
`ifdef CLK_FREQ_METER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_in) begin
        sync_q <= rst ? 2'b00 : {sync_q[0], bus.sig_in};
    end
    assign sig_s = sync_q[1];
`else
    assign sig_s = bus.sig_in;
`endif
    edge_interval_tracker #(.CNT_W(CNT_W)) u_trk (
        .clk_in (clk_in),
        .rst    (rst),
        .clr_i  (clr),
        .en_i   (en),
        .sig_i  (sig_s),
        .cnt_o  (trk_cnt),
        .min_o  (trk_min),
        .max_o  (trk_max)
    );
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        exp_d   = exp_q;
        clr     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = GATE;
                    exp_d   = bus.exp_cnt;
                    win_d   = '0;
                    clr     = 1'b1;
                end
            end
            GATE: begin
                en    = 1'b1;
                win_d = win_q + 1'b1;
                if (win_q == LAST) begin
                    state_d = DONE;
                    win_d   = '0;
                    load    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Results are captured entering DONE so they are visible during the valid cycle
        edge_cnt_d = load ? trk_cnt : edge_cnt_q;
        pmin_d     = load ? trk_min : pmin_q;
        pmax_d     = load ? trk_max : pmax_q;
        match_d    = load ? (abs_diff((MAX_W+1)'(trk_cnt), (MAX_W+1)'(exp_q)) <= (MAX_W+1)'(TOL)) : match_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            exp_q      <= '0;
            edge_cnt_q <= '0;
            pmin_q     <= '0;
            pmax_q     <= '0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            exp_q      <= exp_d;
            edge_cnt_q <= edge_cnt_d;
            pmin_q     <= pmin_d;
            pmax_q     <= pmax_d;
            match_q    <= match_d;
        end
    end
    assign bus.busy       = state_q == GATE;
    assign bus.valid      = state_q == DONE;
    assign bus.edge_cnt   = edge_cnt_q;
    assign bus.period_min = pmin_q;
    assign bus.period_max = pmax_q;
    assign bus.match      = match_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: directed checks of clk_freq_meter across three configurations
module tb_clk_freq_meter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sig;
    logic [31:0] exp_v;
    int          sel;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        busy, valid, match;
    logic [31:0] ecnt, pmin, pmax;
    always #5 clk = ~clk;
    clk_freq_meter_if #(.CNT_W(16)) if_a ();
    clk_freq_meter_if #(.CNT_W(16)) if_b ();
    clk_freq_meter_if #(.CNT_W(4))  if_c ();
    assign if_a.start   = start && sel == 0;
    assign if_b.start   = start && sel == 1;
    assign if_c.start   = start && sel == 2;
    assign if_a.sig_in  = sig && sel == 0;
    assign if_b.sig_in  = sig && sel == 1;
    assign if_c.sig_in  = sig && sel == 2;
    assign if_a.exp_cnt = exp_v[15:0];
    assign if_b.exp_cnt = exp_v[15:0];
    assign if_c.exp_cnt = exp_v[3:0];
    clk_freq_meter #(.GATE_CYCLES(100), .CNT_W(16), .TOL(1)) u_a (.clk_in(clk), .rst(rst), .bus(if_a));
    clk_freq_meter #(.GATE_CYCLES(90),  .CNT_W(16), .TOL(1)) u_b (.clk_in(clk), .rst(rst), .bus(if_b));
    clk_freq_meter #(.GATE_CYCLES(100), .CNT_W(4),  .TOL(1)) u_c (.clk_in(clk), .rst(rst), .bus(if_c));
    always_comb begin
        busy  = sel == 0 ? if_a.busy  : sel == 1 ? if_b.busy  : if_c.busy;
        valid = sel == 0 ? if_a.valid : sel == 1 ? if_b.valid : if_c.valid;
        match = sel == 0 ? if_a.match : sel == 1 ? if_b.match : if_c.match;
        ecnt  = sel == 0 ? 32'(if_a.edge_cnt)   : sel == 1 ? 32'(if_b.edge_cnt)   : 32'(if_c.edge_cnt);
        pmin  = sel == 0 ? 32'(if_a.period_min) : sel == 1 ? 32'(if_b.period_min) : 32'(if_c.period_min);
        pmax  = sel == 0 ? 32'(if_a.period_max) : sel == 1 ? 32'(if_b.period_max) : 32'(if_c.period_max);
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask
    // sig_in value for cycle T+t of a window
    function automatic logic pat(input int m, input int t);
        case (m)
            1:       return (t + 3) % 4 < 2;
            2:       return t % 2 == 1;
            3:       return t % 9 == 1 || t % 9 == 2 || t % 9 == 5 || t % 9 == 6;
            4:       return t == 5;
            5:       return t == 0 || t == 100;
            6:       return t == 101;
            7:       return t == 1 || t == 30;
            default: return 1'b0;
        endcase
    endfunction
    task automatic run(input int s, input int m, input int g, input int ex, input bit dup,
                       input int rst_at, output int nv, output int vt);
        sel   = s;
        exp_v = 32'(ex);
        nv    = 0;
        vt    = -1;
        for (int t = 0; t <= g + 2; t++) begin
            start = t == 0 || (dup && (t == 10 || t == 50 || t == g + 1));
            sig   = pat(m, t);
            rst   = t == rst_at;
            @(negedge clk);
            if (valid) begin
                nv++;
                vt = t;
            end
            if (t == 1) check("busy_first", 32'(busy), 1);
            if (t == g && rst_at < 0) check("busy_last", 32'(busy), 1);
            if (t == g + 2) check("busy_after", 32'(busy), 0);
            if (t == rst_at + 1 && rst_at >= 0) begin
                check("rst_busy", 32'(busy), 0);
                check("rst_valid", 32'(valid), 0);
                check("rst_edge", ecnt, 0);
                check("rst_pmin", pmin, 0);
                check("rst_pmax", pmax, 0);
                check("rst_match", 32'(match), 0);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        sig   = 1'b0;
        rst   = 1'b0;
    endtask
    task automatic meas(input string tag, input int s, input int m, input int g, input int ex,
                        input int e_cnt, input int e_min, input int e_max, input int e_match);
        int nv, vt;
        run(s, m, g, ex, 1'b0, -1, nv, vt);
        check({tag, "_nvalid"}, 32'(nv), 1);
        check({tag, "_vtime"}, 32'(vt), 32'(g + 1));
        check({tag, "_edge"}, ecnt, 32'(e_cnt));
        check({tag, "_pmin"}, pmin, 32'(e_min));
        check({tag, "_pmax"}, pmax, 32'(e_max));
        check({tag, "_match"}, 32'(match), 32'(e_match));
    endtask
    initial begin
        int nv, vt;
        rst   = 1'b1;
        start = 1'b0;
        sig   = 1'b0;
        exp_v = '0;
        sel   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst0_busy", 32'(busy), 0);
        check("rst0_valid", 32'(valid), 0);
        check("rst0_edge", ecnt, 0);
        check("rst0_pmin", pmin, 0);
        check("rst0_pmax", pmax, 0);
        check("rst0_match", 32'(match), 0);
        @(posedge clk);
        #1;
        meas("div4",     0, 1, 100, 25, 25, 4, 4, 1);
        meas("div45",    1, 3, 90,  20, 20, 4, 5, 1);
        meas("zero",     0, 0, 100, 5,  0,  0, 0, 0);
        meas("div4_e26", 0, 1, 100, 26, 25, 4, 4, 1);
        meas("div4_e27", 0, 1, 100, 27, 25, 4, 4, 0);
        meas("div4_e23", 0, 1, 100, 23, 25, 4, 4, 0);
        meas("single",   0, 4, 100, 1,  1,  0, 0, 1);
        meas("edges_tw", 0, 5, 100, 1,  1,  0, 0, 1);
        meas("done_rise",0, 6, 100, 0,  0,  0, 0, 1);
        run(0, 1, 100, 25, 1'b1, -1, nv, vt);
        check("dup_nvalid", 32'(nv), 1);
        check("dup_vtime", 32'(vt), 101);
        check("dup_edge", ecnt, 25);
        run(0, 1, 100, 25, 1'b0, 40, nv, vt);
        check("abort_nvalid", 32'(nv), 0);
        meas("post_rst", 0, 1, 100, 25, 25, 4, 4, 1);
        meas("sat_e50",  2, 2, 100, 50, 15, 2, 2, 0);
        meas("sat_e14",  2, 2, 100, 14, 15, 2, 2, 1);
        meas("nowrap",   2, 0, 100, 15, 0,  0, 0, 0);
        meas("ivl_sat",  2, 7, 100, 2,  2, 15, 15, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
